// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: the active-low seven-segment code
// table, the blank code, the BCD digit limits and the digit-select names.
package stopwatch_pkg;

    localparam int NUM_SEG_CODES = 10;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SSEG_TABLE [NUM_SEG_CODES] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [6:0] SSEG_BLANK = 7'b1111111;

    // Rollover points: tenths, seconds-units and minutes wrap after 9,
    // seconds-tens wraps after 5.
    localparam logic [3:0] DIGIT_MAX_NINE = 4'd9;
    localparam logic [3:0] DIGIT_MAX_FIVE = 4'd5;

    // Digit selected by the two MSBs of the refresh counter.
    typedef enum logic [1:0] {
        SEL_TENTHS  = 2'd0,
        SEL_SECONDS = 2'd1,
        SEL_TENS    = 2'd2,
        SEL_MINUTES = 2'd3
    } digit_sel_t;

endpackage

// File: rtl/sseg_decoder.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 are blanked.
module sseg_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for legal digits, all segments dark otherwise.
    always_comb begin
        seg = SSEG_BLANK;
        if (bcd <= DIGIT_MAX_NINE) begin
            seg = SSEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/stopwatch.sv
// Four-digit M:SS.t stopwatch: a divider produces 0.1 s ticks that drive a
// BCD counter chain, and a refresh counter time-multiplexes the digits onto
// one seven-segment display.
module stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV     = 10_000_000,
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       clr,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [3:0] an,
    output logic [6:0] sseg,
    output logic       dp
);

    localparam int              TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [1:0]              rst_sync;
    logic                    run_ok;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic [REFRESH_BITS-1:0] refresh;
    digit_sel_t              sel;
    logic [3:0]              digit;

    // Reset asserts immediately but releases through two flops so every
    // counter starts advancing on the same, metastability-free edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_ok = rst_sync[1];

    // Tick fires on the last divider count while running; clear wins.
    assign tick = run_ok && go && !clr && (tick_cnt == TICK_LAST);

    // Divider: counts while go is high, holds while low, zeroed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (run_ok) begin
            if (clr) begin
                tick_cnt <= '0;
            end else if (go) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
            end
        end
    end

    // BCD chain: every carry resolves on the tick edge; 9:59.9 wraps to 0:00.0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0 <= 4'd0;
            d1 <= 4'd0;
            d2 <= 4'd0;
            d3 <= 4'd0;
        end else if (run_ok) begin
            if (clr) begin
                d0 <= 4'd0;
                d1 <= 4'd0;
                d2 <= 4'd0;
                d3 <= 4'd0;
            end else if (tick) begin
                if (d0 != DIGIT_MAX_NINE) begin
                    d0 <= d0 + 4'd1;
                end else begin
                    d0 <= 4'd0;
                    if (d1 != DIGIT_MAX_NINE) begin
                        d1 <= d1 + 4'd1;
                    end else begin
                        d1 <= 4'd0;
                        if (d2 != DIGIT_MAX_FIVE) begin
                            d2 <= d2 + 4'd1;
                        end else begin
                            d2 <= 4'd0;
                            d3 <= (d3 != DIGIT_MAX_NINE) ? d3 + 4'd1 : 4'd0;
                        end
                    end
                end
            end
        end
    end

    // Free-running refresh counter; unaffected by go and clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh <= '0;
        end else if (run_ok) begin
            refresh <= refresh + REFRESH_BITS'(1);
        end
    end

    assign sel = digit_sel_t'(refresh[REFRESH_BITS-1 -: 2]);

    // Digit multiplexer: one anode low at a time, decimal points after the
    // minutes and seconds-units digits.
    always_comb begin
        an    = 4'b1110;
        digit = d0;
        dp    = 1'b1;
        case (sel)
            SEL_TENTHS: begin
                an    = 4'b1110;
                digit = d0;
                dp    = 1'b1;
            end
            SEL_SECONDS: begin
                an    = 4'b1101;
                digit = d1;
                dp    = 1'b0;
            end
            SEL_TENS: begin
                an    = 4'b1011;
                digit = d2;
                dp    = 1'b1;
            end
            SEL_MINUTES: begin
                an    = 4'b0111;
                digit = d3;
                dp    = 1'b0;
            end
            default: begin
                an    = 4'b1110;
                digit = d0;
                dp    = 1'b1;
            end
        endcase
    end

    sseg_decoder u_sseg_decoder (
        .bcd (digit),
        .seg (sseg)
    );

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench for the stopwatch with a fast divider and short
// refresh counter. The reference model keeps elapsed time as a plain count
// of tenths and derives the digits arithmetically.
module tb_stopwatch;

    localparam int TICK_DIV     = 10;
    localparam int REFRESH_BITS = 4;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic       clr;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;

    int tests_run;
    int tests_failed;

    // Reference state: elapsed tenths, divider phase, refresh count and the
    // number of edges seen since reset release.
    int m_total;
    int m_phase;
    int m_refresh;
    int m_sync;

    stopwatch #(
        .TICK_DIV     (TICK_DIV),
        .REFRESH_BITS (REFRESH_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .clr   (clr),
        .d3    (d3),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0),
        .an    (an),
        .sseg  (sseg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model advanced on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_total   = 0;
            m_phase   = 0;
            m_refresh = 0;
            m_sync    = 0;
        end else if (m_sync < 2) begin
            m_sync = m_sync + 1;
        end else begin
            m_refresh = (m_refresh + 1) % (1 << REFRESH_BITS);
            if (clr) begin
                m_total = 0;
                m_phase = 0;
            end else if (go) begin
                m_phase = m_phase + 1;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    m_total = (m_total + 1) % 6000;
                end
            end
        end
    end

    function automatic logic [15:0] model_digits();
        return {4'(m_total / 600), 4'((m_total / 100) % 6),
                4'((m_total / 10) % 10), 4'(m_total % 10)};
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go    = 1'b0;
        clr   = 1'b0;
        cycles(3);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_digits got %h want 0000", {d3, d2, d1, d0});
        end
        tests_run++;
        if (an !== 4'b1110) begin
            tests_failed++;
            $display("[TB] FAIL reset_an got %b want 1110", an);
        end
        tests_run++;
        if (sseg !== 7'b1000000) begin
            tests_failed++;
            $display("[TB] FAIL reset_sseg got %b want 1000000", sseg);
        end
        tests_run++;
        if (dp !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_dp got %b want 1", dp);
        end
        rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_ten_ticks();
        go = 1'b1;
        cycles(10 * TICK_DIV);
        go = 1'b0;
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0010) begin
            tests_failed++;
            $display("[TB] FAIL ten_ticks got %h want 0010", {d3, d2, d1, d0});
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== model_digits()) begin
            tests_failed++;
            $display("[TB] FAIL ten_ticks_model got %h want %h", {d3, d2, d1, d0}, model_digits());
        end
    endtask

    task automatic test_pause();
        logic [15:0] snap;
        for (int r = 0; r < 3; r++) begin
            go = 1'b1;
            cycles($urandom_range(5, 40));
            go = 1'b0;
            snap = {d3, d2, d1, d0};
            cycles(50);
            tests_run++;
            if ({d3, d2, d1, d0} !== snap) begin
                tests_failed++;
                $display("[TB] FAIL pause_hold got %h want %h", {d3, d2, d1, d0}, snap);
            end
            go = 1'b1;
            cycles($urandom_range(5, 40));
            go = 1'b0;
            tests_run++;
            if ({d3, d2, d1, d0} !== model_digits()) begin
                tests_failed++;
                $display("[TB] FAIL pause_resume got %h want %h", {d3, d2, d1, d0}, model_digits());
            end
        end
    endtask

    task automatic test_clear_on_tick();
        go  = 1'b0;
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        go  = 1'b1;
        cycles(25 * TICK_DIV + TICK_DIV - 1);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0025) begin
            tests_failed++;
            $display("[TB] FAIL clr_setup got %h want 0025", {d3, d2, d1, d0});
        end
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL clr_on_tick got %h want 0000", {d3, d2, d1, d0});
        end
        cycles(TICK_DIV - 1);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL clr_no_early_tick got %h want 0000", {d3, d2, d1, d0});
        end
        cycles(1);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL clr_restart got %h want 0001", {d3, d2, d1, d0});
        end
        go = 1'b0;
    endtask

    task automatic test_minute_carry();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        go  = 1'b1;
        for (int i = 0; i < 599 * TICK_DIV; i++) begin
            @(negedge clk);
            if (i % 97 == 0) begin
                tests_run++;
                if ({d3, d2, d1, d0} !== model_digits()) begin
                    tests_failed++;
                    $display("[TB] FAIL carry_run got %h want %h", {d3, d2, d1, d0}, model_digits());
                end
            end
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0599) begin
            tests_failed++;
            $display("[TB] FAIL carry_preload got %h want 0599", {d3, d2, d1, d0});
        end
        cycles(TICK_DIV);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h1000) begin
            tests_failed++;
            $display("[TB] FAIL minute_carry got %h want 1000", {d3, d2, d1, d0});
        end
    endtask

    task automatic test_display();
        logic [3:0] seen;
        logic [3:0] dig;
        int         s;
        go = 1'b1;
        cycles((2275 - 600) * TICK_DIV);
        go = 1'b0;
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h3475) begin
            tests_failed++;
            $display("[TB] FAIL display_setup got %h want 3475", {d3, d2, d1, d0});
        end
        seen = 4'b0000;
        for (int i = 0; i < (1 << REFRESH_BITS); i++) begin
            @(negedge clk);
            s   = m_refresh >> (REFRESH_BITS - 2);
            dig = 4'((m_total / ((s == 0) ? 1 : (s == 1) ? 10 : (s == 2) ? 100 : 600))
                     % ((s == 2) ? 6 : 10));
            seen[s] = 1'b1;
            tests_run++;
            if (an !== ~(4'b0001 << s)) begin
                tests_failed++;
                $display("[TB] FAIL display_an got %b want %b", an, ~(4'b0001 << s));
            end
            tests_run++;
            if (sseg !== ref_seg(dig)) begin
                tests_failed++;
                $display("[TB] FAIL display_sseg got %b want %b", sseg, ref_seg(dig));
            end
            tests_run++;
            if (dp !== ((s % 2) == 0)) begin
                tests_failed++;
                $display("[TB] FAIL display_dp got %b want %b", dp, (s % 2) == 0);
            end
        end
        tests_run++;
        if (seen !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL display_sweep got %b want 1111", seen);
        end
    endtask

    task automatic test_wrap();
        go = 1'b1;
        for (int i = 0; i < (5999 - 2275) * TICK_DIV; i++) begin
            @(negedge clk);
            if (i % 211 == 0) begin
                tests_run++;
                if ({d3, d2, d1, d0} !== model_digits()) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_run got %h want %h", {d3, d2, d1, d0}, model_digits());
                end
            end
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h9599) begin
            tests_failed++;
            $display("[TB] FAIL wrap_preload got %h want 9599", {d3, d2, d1, d0});
        end
        cycles(TICK_DIV);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL wrap got %h want 0000", {d3, d2, d1, d0});
        end
    endtask

    task automatic test_async_reset();
        go = 1'b1;
        cycles($urandom_range(30, 60));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL async_rst_digits got %h want 0000", {d3, d2, d1, d0});
        end
        tests_run++;
        if ({an, sseg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL async_rst_display got %b %b %b want 1110 1000000 1", an, sseg, dp);
        end
        cycles(3);
        #1;
        rst_n = 1'b1;
        cycles(12);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL async_restart got %h want 0001", {d3, d2, d1, d0});
        end
        cycles($urandom_range(20, 80));
        tests_run++;
        if ({d3, d2, d1, d0} !== model_digits()) begin
            tests_failed++;
            $display("[TB] FAIL async_run got %h want %h", {d3, d2, d1, d0}, model_digits());
        end
        go = 1'b0;
    endtask

    // Scenario sequence; later tasks build on the count left by earlier ones.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_ten_ticks();
        test_pause();
        test_clear_on_tick();
        test_minute_carry();
        test_display();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
